// File: rtl/dmem_lsu.sv
// Parametrised data memory with an RV32I load/store front end.
// One request in flight; byte-lane stores, extended loads, READ_LAT 1..4.
module dmem_lsu #(
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = $clog2(DEPTH) + 2,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [1:0] CNT_INIT =
        (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [31:0]      mem [DEPTH];
    logic [31:0]      rd_q;
    logic [1:0]       cnt;
    logic             we_q;
    logic             uns_q;
    logic             err_q;
    logic [1:0]       size_q;
    logic [1:0]       lane_q;

    logic             accept;
    logic             err;
    logic [3:0]       be;
    logic [31:0]      wd;
    logic [31:0]      sh;
    logic [31:0]      ext;
    logic [IDX_W-1:0] idx;

    assign idx       = req_addr[ADDR_W-1:2];
    assign req_ready = !reset || (state == IDLE);
    assign accept    = reset && req_valid && (state == IDLE);

    always_comb begin
        err = 1'b0;
        be  = 4'b0000;
        wd  = req_wdata;
        unique case (req_size)
            2'b00: begin
                be = 4'b0001 << req_addr[1:0];
                wd = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                err = req_addr[0];
                be  = req_addr[1] ? 4'b1100 : 4'b0011;
                wd  = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                err = |req_addr[1:0];
                be  = 4'b1111;
            end
            default: err = 1'b1;
        endcase
    end

    // Lane select and extension use only the fields captured at acceptance.
    always_comb begin
        sh  = rd_q >> {lane_q, 3'b000};
        ext = sh;
        unique case (size_q)
            2'b00:   ext = {{24{!uns_q && sh[7]}}, sh[7:0]};
            2'b01:   ext = {{16{!uns_q && sh[15]}}, sh[15:0]};
            default: ext = sh;
        endcase
    end

    always_comb begin
        state_nx  = state;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 32'd0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (err || req_we || READ_LAT == 1)
                        state_nx = RESP;
                    else
                        state_nx = BUSY;
                end
            end
            BUSY: begin
                if (cnt == 2'd0)
                    state_nx = RESP;
            end
            RESP: begin
                state_nx  = IDLE;
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                if (!err_q && !we_q)
                    rsp_rdata = ext;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= 2'd0;
            rd_q   <= 32'd0;
            we_q   <= 1'b0;
            uns_q  <= 1'b0;
            err_q  <= 1'b0;
            size_q <= 2'd0;
            lane_q <= 2'd0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 32'd0;
        end else if (accept) begin
            cnt    <= CNT_INIT;
            we_q   <= req_we;
            uns_q  <= req_unsigned;
            err_q  <= err;
            size_q <= req_size;
            lane_q <= req_addr[1:0];
            if (!req_we)
                rd_q <= mem[idx];
            if (req_we && !err) begin
                for (int b = 0; b < 4; b++)
                    if (be[b])
                        mem[idx][8*b +: 8] <= wd[8*b +: 8];
            end
        end else if (state == BUSY && cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: three instances (READ_LAT 1, 3, 4) share stimulus
// and are checked every cycle against a byte-array reference model.
module tb_dmem_lsu;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [7:0]  req_addr = 8'd0;
    logic [31:0] req_wdata = 32'd0;

    logic        rdy   [N];
    logic        vld   [N];
    logic        err   [N];
    logic [31:0] rdata [N];

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        dmem_lsu #(
            .DEPTH   (64),
            .READ_LAT(k == 0 ? 1 : k + 2)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .req_valid   (req_valid),
            .req_ready   (rdy[k]),
            .req_we      (req_we),
            .req_size    (req_size),
            .req_unsigned(req_unsigned),
            .req_addr    (req_addr),
            .req_wdata   (req_wdata),
            .rsp_valid   (vld[k]),
            .rsp_rdata   (rdata[k]),
            .rsp_err     (err[k])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : k + 2;
    endfunction

    // Reference model: byte-addressed memory per instance plus the
    // cycle at which each instance owes its response.
    logic [7:0]  mb     [N][256];
    int          resp_at[N];
    logic [31:0] exp_d  [N];
    logic        exp_e  [N];
    int          cyc = 0;

    int checks = 0;
    int fails  = 0;

    logic        got_v [N];
    logic [31:0] got_d [N];
    logic        got_e [N];
    int          got_c [N];

    task automatic chk(input string name, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h",
                     name, k, cyc, act, exp);
        end
    endtask

    task automatic model_accept(input int k);
        int a;
        int n;
        logic [31:0] v;
        a = int'(req_addr);
        n = 1 << req_size;
        if (req_size == 2'b11 || (a % n) != 0) begin
            exp_d[k]   = 32'd0;
            exp_e[k]   = 1'b1;
            resp_at[k] = cyc + 1;
        end else if (req_we) begin
            for (int i = 0; i < n; i++)
                mb[k][a+i] = req_wdata[8*i +: 8];
            exp_d[k]   = 32'd0;
            exp_e[k]   = 1'b0;
            resp_at[k] = cyc + 1;
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++)
                v[8*i +: 8] = mb[k][a+i];
            if (!req_unsigned && n < 4 && v[8*n-1])
                for (int i = n; i < 4; i++)
                    v[8*i +: 8] = 8'hFF;
            exp_d[k]   = v;
            exp_e[k]   = 1'b0;
            resp_at[k] = cyc + lat_of(k);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            resp_at[k] = -1;
            got_v[k]   = 1'b0;
        end
        forever begin
            @(posedge clk);
            if (!reset) begin
                for (int k = 0; k < N; k++) begin
                    resp_at[k] = -1;
                    for (int a = 0; a < 256; a++)
                        mb[k][a] = 8'd0;
                end
            end else if (req_valid) begin
                for (int k = 0; k < N; k++)
                    if (cyc > resp_at[k])
                        model_accept(k);
            end
            cyc = cyc + 1;
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                for (int k = 0; k < N; k++) begin
                    logic ev;
                    logic er;
                    ev = (cyc == resp_at[k]);
                    er = !reset || (cyc > resp_at[k]);
                    chk("req_ready", k, 32'(rdy[k]), 32'(er));
                    chk("rsp_valid", k, 32'(vld[k]), 32'(ev));
                    chk("rsp_rdata", k, rdata[k],
                        ev ? exp_d[k] : 32'd0);
                    chk("rsp_err", k, 32'(err[k]),
                        32'(ev && exp_e[k]));
                    if (vld[k]) begin
                        got_v[k] = 1'b1;
                        got_d[k] = rdata[k];
                        got_e[k] = err[k];
                        got_c[k] = cyc;
                    end
                end
            end
        end
    end

    task automatic op(input logic we, input logic [1:0] size,
                      input logic uns, input logic [7:0] addr,
                      input logic [31:0] wdata,
                      input logic [31:0] expd, input logic expe);
        int acc;
        @(posedge clk);
        #1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        for (int k = 0; k < N; k++)
            got_v[k] = 1'b0;
        @(posedge clk);
        #1;
        acc       = cyc - 1;
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            int el;
            el = (we || expe) ? 1 : lat_of(k);
            chk("rsp_seen", k, 32'(got_v[k]), 32'd1);
            chk("lit_rdata", k, got_d[k], expd);
            chk("lit_err", k, 32'(got_e[k]), 32'(expe));
            chk("latency", k, 32'(got_c[k] - acc), 32'(el));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            chk("rst_ready", k, 32'(rdy[k]), 32'd1);
            chk("rst_valid", k, 32'(vld[k]), 32'd0);
        end
        reset = 1'b1;

        op(1'b0, 2'b10, 1'b0, 8'h00, 32'd0, 32'h0000_0000, 1'b0);

        op(1'b1, 2'b10, 1'b0, 8'h08, 32'hDEAD_BEEF, 32'd0, 1'b0);
        op(1'b0, 2'b10, 1'b0, 8'h08, 32'd0, 32'hDEAD_BEEF, 1'b0);

        op(1'b0, 2'b00, 1'b0, 8'h0B, 32'd0, 32'hFFFF_FFDE, 1'b0);
        op(1'b0, 2'b00, 1'b1, 8'h0B, 32'd0, 32'h0000_00DE, 1'b0);
        op(1'b0, 2'b01, 1'b0, 8'h08, 32'd0, 32'hFFFF_BEEF, 1'b0);

        op(1'b1, 2'b01, 1'b0, 8'h0A, 32'h0000_1234, 32'd0, 1'b0);
        op(1'b0, 2'b10, 1'b0, 8'h08, 32'd0, 32'h1234_BEEF, 1'b0);
        op(1'b1, 2'b00, 1'b0, 8'h09, 32'h0000_0055, 32'd0, 1'b0);
        op(1'b0, 2'b10, 1'b0, 8'h08, 32'd0, 32'h1234_55EF, 1'b0);

        op(1'b1, 2'b10, 1'b0, 8'h04, 32'h1122_3344, 32'd0, 1'b0);
        op(1'b1, 2'b10, 1'b0, 8'h05, 32'hAAAA_AAAA, 32'd0, 1'b1);
        op(1'b0, 2'b01, 1'b0, 8'h03, 32'd0, 32'd0, 1'b1);
        op(1'b1, 2'b11, 1'b0, 8'h04, 32'hFFFF_FFFF, 32'd0, 1'b1);
        op(1'b0, 2'b11, 1'b0, 8'h04, 32'd0, 32'd0, 1'b1);
        op(1'b0, 2'b10, 1'b0, 8'h04, 32'd0, 32'h1122_3344, 1'b0);

        op(1'b1, 2'b10, 1'b0, 8'hFC, 32'hA5A5_0F0F, 32'd0, 1'b0);
        op(1'b0, 2'b01, 1'b1, 8'hFE, 32'd0, 32'h0000_A5A5, 1'b0);
        op(1'b0, 2'b01, 1'b0, 8'hFE, 32'd0, 32'hFFFF_A5A5, 1'b0);
        op(1'b0, 2'b00, 1'b0, 8'hFC, 32'd0, 32'h0000_000F, 1'b0);

        // Abort: load accepted, request held while busy, reset mid-flight.
        @(posedge clk);
        #1;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 8'h08;
        req_valid    = 1'b1;
        for (int k = 0; k < N; k++)
            got_v[k] = 1'b0;
        @(posedge clk);
        #1;
        req_we    = 1'b1;
        req_addr  = 8'h10;
        req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < N; k++)
            chk("post_rst_ready", k, 32'(rdy[k]), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_lat1_resp", 0, 32'(got_v[0]), 32'd1);
        chk("abort_lat3_resp", 1, 32'(got_v[1]), 32'd0);
        chk("abort_lat4_resp", 2, 32'(got_v[2]), 32'd0);

        op(1'b0, 2'b10, 1'b0, 8'h08, 32'd0, 32'h0000_0000, 1'b0);
        op(1'b0, 2'b10, 1'b0, 8'h10, 32'd0, 32'h0000_0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
